// File: rtl/multi_seq_if.sv
// Handshake and operand/result bundle between the execute-stage controller and multi_seq.
// master = controller side, slave = multiplier side.
interface multi_seq_if #(
    parameter int unsigned REG_W = 8,
    parameter int unsigned IMM_W = 5
);

    logic             start;
    logic [REG_W-1:0] register_in;
    logic [IMM_W-1:0] immediate_in;
    logic             busy;
    logic             done;
    logic [REG_W-1:0] result;

    modport master (
        output start,
        output register_in,
        output immediate_in,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  register_in,
        input  immediate_in,
        output busy,
        output done,
        output result
    );

endinterface

// File: rtl/multi_seq.sv
// Multi-cycle signed fixed-point multiplier: result = (register_in * immediate_in) >>> FRAC_BITS,
// one shift-add step per clock. Define MULTI_SEQ_SATURATE_EN to clamp instead of wrap.
module multi_seq #(
    parameter int unsigned REG_W     = 8,
    parameter int unsigned IMM_W     = 5,
    parameter int unsigned FRAC_BITS = 3
) (
    input logic        clk,
    input logic        reset,
    multi_seq_if.slave bus
);

    localparam int unsigned PW   = REG_W + IMM_W;
    localparam int unsigned CntW = (IMM_W > 1) ? $clog2(IMM_W) : 1;
    localparam logic [CntW-1:0] LastStep = CntW'(IMM_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                state_q,  state_d;
    logic [REG_W-1:0]      mcand_q,  mcand_d;
    logic [IMM_W-1:0]      mplier_q, mplier_d;
    logic signed [PW-1:0]  acc_q,    acc_d;
    logic [CntW-1:0]       cnt_q,    cnt_d;
    logic [REG_W-1:0]      result_q, result_d;

    logic signed [PW-1:0]  mcand_ext;
    logic signed [PW-1:0]  addend;
    logic signed [PW-1:0]  acc_step;
    logic                  last_step;
    logic [REG_W-1:0]      result_fmt;

    // One Booth-free shift-add step; the multiplier MSB carries negative weight.
    always_comb begin
        mcand_ext = {{IMM_W{mcand_q[REG_W-1]}}, mcand_q};
        addend    = mcand_ext << cnt_q;
        last_step = (cnt_q == LastStep);
        acc_step  = acc_q;
        if (mplier_q[cnt_q]) begin
            acc_step = last_step ? (acc_q - addend) : (acc_q + addend);
        end
    end

`ifdef MULTI_SEQ_SATURATE_EN
    localparam logic signed [PW-1:0] SatMax = {{(IMM_W + 1){1'b0}}, {(REG_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SatMin = {{(IMM_W + 1){1'b1}}, {(REG_W - 1){1'b0}}};

    logic signed [PW-1:0] scaled;

    always_comb begin
        scaled = acc_step >>> FRAC_BITS;
        if (scaled > SatMax) begin
            result_fmt = SatMax[REG_W-1:0];
        end else if (scaled < SatMin) begin
            result_fmt = SatMin[REG_W-1:0];
        end else begin
            result_fmt = scaled[REG_W-1:0];
        end
    end
`else
    // Wrapping keeps only the low REG_W bits of the shifted product; assumes FRAC_BITS <= IMM_W.
    always_comb begin
        result_fmt = acc_step[REG_W+FRAC_BITS-1:FRAC_BITS];
    end
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    state_d  = StRun;
                    mcand_d  = bus.register_in;
                    mplier_d = bus.immediate_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d  = StDone;
                    result_d = result_fmt;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == StRun);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;

endmodule

// File: tb/tb_multi_seq.sv
// Self-checking bench for multi_seq: a per-cycle reference model plus directed literal cases.
// Define MULTI_SEQ_SATURATE_EN for both DUT and bench to check the clamping build.
module tb_multi_seq;

    localparam int unsigned REG_W     = 8;
    localparam int unsigned IMM_W     = 5;
    localparam int unsigned FRAC_BITS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    multi_seq_if #(.REG_W(REG_W), .IMM_W(IMM_W)) bus_if ();

    multi_seq #(
        .REG_W    (REG_W),
        .IMM_W    (IMM_W),
        .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic logic [REG_W-1:0] calc(input logic [REG_W-1:0] r,
                                              input logic [IMM_W-1:0] i);
        int rr;
        int ii;
        int s;
        rr = $signed(r);
        ii = $signed(i);
        s  = (rr * ii) >>> FRAC_BITS;
`ifdef MULTI_SEQ_SATURATE_EN
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return REG_W'(s);
    endfunction

    // Model: an accepted op stays busy IMM_W cycles, then shows its result with a done pulse.
    int               m_left = 0;
    logic             m_done = 1'b0;
    logic [REG_W-1:0] m_result = '0;
    logic [REG_W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left   = 0;
            m_done   = 1'b0;
            m_result = '0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) m_result = m_pend;
        end else begin
            m_done = 1'b0;
            if (bus_if.start) begin
                m_left = IMM_W;
                m_pend = calc(bus_if.register_in, bus_if.immediate_in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",   bus_if.busy,   m_left > 0);
            check("cyc_done",   bus_if.done,   m_done);
            check("cyc_result", bus_if.result, m_result);
        end
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_if.done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Called on a negedge; returns on the negedge of the done cycle.
    task automatic run_op(input logic [REG_W-1:0] r, input logic [IMM_W-1:0] i,
                          input logic [REG_W-1:0] lit, input string name);
        int lat;
        bus_if.start        = 1'b1;
        bus_if.register_in  = r;
        bus_if.immediate_in = i;
        @(negedge clk);
        bus_if.start = 1'b0;
        check({name, "_busy"}, bus_if.busy, 1);
        wait_done(lat);
        check({name, "_lat"}, lat, 4);
        check({name, "_res"}, bus_if.result, lit);
        check({name, "_model"}, m_result, lit);
    endtask

    initial begin
        int lat;
        int q[$];
        bus_if.start        = 1'b0;
        bus_if.register_in  = '0;
        bus_if.immediate_in = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy",   bus_if.busy,   0);
        check("rst_done",   bus_if.done,   0);
        check("rst_result", bus_if.result, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'h06, 5'b00110, 8'h04, "t1");
        run_op(8'h08, 5'b01100, 8'h0C, "t2a");
        run_op(8'h80, 5'b00100, 8'hC0, "t2b");
        run_op(8'hF7, 5'b00100, 8'hFB, "t3");
`ifdef MULTI_SEQ_SATURATE_EN
        run_op(8'h7F, 5'b01111, 8'h7F, "t4a");
        run_op(8'h80, 5'b10000, 8'h7F, "t4b");
        run_op(8'h80, 5'b01111, 8'h80, "t4c");
`else
        run_op(8'h7F, 5'b01111, 8'hEE, "t4a");
        run_op(8'h80, 5'b10000, 8'h00, "t4b");
        run_op(8'h80, 5'b01111, 8'h10, "t4c");
`endif
        run_op(8'h00, 5'b01111, 8'h00, "zero");

        // start held high: accepted from DONE each time, done every 6 cycles
        bus_if.start        = 1'b1;
        bus_if.register_in  = 8'h08;
        bus_if.immediate_in = 5'b01100;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus_if.done) q.push_back(i);
        end
        bus_if.start = 1'b0;
        check("held_cnt", q.size(), 3);
        if (q.size() == 3) begin
            for (int k = 0; k < 3; k++) check("held_pos", q[k], 5 + 6 * k);
        end
        check("held_res", bus_if.result, 8'h0C);

        // start pulse mid-RUN with new operands must be ignored
        @(negedge clk);
        bus_if.start        = 1'b1;
        bus_if.register_in  = 8'h06;
        bus_if.immediate_in = 5'b00110;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start        = 1'b1;
        bus_if.register_in  = 8'h7F;
        bus_if.immediate_in = 5'b01111;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_done(lat);
        check("mid_lat", lat, 2);
        check("mid_res", bus_if.result, 8'h04);

        // reset on the 3rd RUN cycle aborts the op
        @(negedge clk);
        bus_if.start        = 1'b1;
        bus_if.register_in  = 8'h08;
        bus_if.immediate_in = 5'b01100;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   bus_if.busy,   0);
        check("abort_done",   bus_if.done,   0);
        check("abort_result", bus_if.result, 0);
        q.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_if.done) q.push_back(i);
        end
        check("abort_nodone", q.size(), 0);
        run_op(8'h06, 5'b00110, 8'h04, "t6");

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
